// File: rtl/uart_pkg.sv
// Shared UART constants: drain FSM encodings and default FIFO depth.
// uart_tx keeps its own state constants alongside these.
package uart_pkg;
    localparam int UART_FIFO_DEPTH_DEF = 16;

    typedef enum logic [1:0] {
        S_DRN_IDLE  = 2'd0,
        S_DRN_ISSUE = 2'd1,
        S_DRN_WAIT  = 2'd2
    } drn_state_t;
endpackage

// File: rtl/uart_tx_fifo_if.sv
// Core write path plus uart_tx handshake for uart_tx_fifo.
// The slave modport is the FIFO; the master modport is the core/uart_tx side.
interface uart_tx_fifo_if
    import uart_pkg::*;
#(
    parameter int DEPTH = UART_FIFO_DEPTH_DEF
);
    localparam int AW = $clog2(DEPTH);

    logic          wr_en;
    logic [7:0]    wr_data;
    logic          full;
    logic          empty;
    logic [AW:0]   level;
    logic          overflow;
    logic          ovf_clr;
    logic          busy;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;

    modport slave (
        input  wr_en, wr_data, ovf_clr, tx_ready,
        output full, empty, level, overflow, busy, tx_data, tx_valid
    );

    modport master (
        output wr_en, wr_data, ovf_clr, tx_ready,
        input  full, empty, level, overflow, busy, tx_data, tx_valid
    );
endinterface

// File: rtl/sync_fifo_mem.sv
// DEPTH x 8 storage for uart_tx_fifo: one synchronous write port, one async read port.
// Contents are deliberately not reset.
module sync_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);
    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO between the core write path and uart_tx; issues one byte per uart_tx ready period.
//
// state        | meaning
// S_DRN_IDLE   | wait for tx_ready with data queued, then pop and pulse tx_valid
// S_DRN_ISSUE  | tx_valid high for this single cycle
// S_DRN_WAIT   | wait for uart_tx to drop tx_ready (byte taken)
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = UART_FIFO_DEPTH_DEF
) (
    input logic           clk,
    input logic           rst,
    uart_tx_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   level;
    logic          overflow;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic [7:0]    rd_data;
    drn_state_t    state;
    drn_state_t    state_nxt;
    logic          full;
    logic          empty;
    logic          push;
    logic          drop;
    logic          pop;

    // full is taken from the registered level, so a write alongside a pop while full is dropped
    assign full  = (level == (AW+1)'(DEPTH));
    assign empty = (level == '0);
    assign push  = bus.wr_en && !full;
    assign drop  = bus.wr_en && full;

    sync_fifo_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wptr),
        .wdata (bus.wr_data),
        .raddr (rptr),
        .rdata (rd_data)
    );

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            S_DRN_IDLE: begin
                if (bus.tx_ready && !empty) begin
                    pop       = 1'b1;
                    state_nxt = S_DRN_ISSUE;
                end
            end
            S_DRN_ISSUE: state_nxt = S_DRN_WAIT;
            // only a falling tx_ready matters here; a brief high is ignored
            S_DRN_WAIT: begin
                if (!bus.tx_ready) begin
                    state_nxt = S_DRN_IDLE;
                end
            end
            default: state_nxt = S_DRN_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_DRN_IDLE;
            wptr     <= '0;
            rptr     <= '0;
            level    <= '0;
            overflow <= 1'b0;
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
        end else begin
            state    <= state_nxt;
            tx_valid <= pop;
            if (pop) begin
                tx_data <= rd_data;
                rptr    <= rptr + AW'(1);
            end
            if (push) begin
                wptr <= wptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end else if (bus.ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    assign bus.full     = full;
    assign bus.empty    = empty;
    assign bus.level    = level;
    assign bus.overflow = overflow;
    assign bus.busy     = !empty || (state != S_DRN_IDLE);
    assign bus.tx_data  = tx_data;
    assign bus.tx_valid = tx_valid;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo with a behavioural uart_tx ready model.
module tb_uart_tx_fifo;
    logic clk;
    logic rst;
    logic hold_ready;

    int tests = 0;
    int fails = 0;
    int pulse_cnt = 0;
    logic [7:0] exp_q[$];

    logic prev_valid = 1'b0;
    logic prev_ready = 1'b0;
    logic pulsed_in_period = 1'b0;

    uart_tx_fifo_if #(.DEPTH(16)) bus ();

    uart_tx_fifo #(.DEPTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // uart_tx model: ready drops one cycle after a valid pulse and returns 10 cycles later
    initial begin : uart_model
        bus.tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (hold_ready) begin
                bus.tx_ready = 1'b0;
            end else if (bus.tx_valid) begin
                @(posedge clk);
                #1 bus.tx_ready = 1'b0;
                repeat (10) @(posedge clk);
                #1 bus.tx_ready = !hold_ready;
            end else begin
                bus.tx_ready = 1'b1;
            end
        end
    end

    always @(negedge clk) begin : monitor
        logic [7:0] exp_b;
        if (bus.tx_valid) begin
            pulse_cnt++;
            check("valid_width", {31'd0, prev_valid}, 32'd0);
            check("valid_without_ready", {31'd0, prev_ready}, 32'd1);
            check("double_pulse_in_period", {31'd0, pulsed_in_period}, 32'd0);
            pulsed_in_period = 1'b1;
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", 32'd1, 32'd0);
            end else begin
                exp_b = exp_q.pop_front();
                check("tx_data", {24'd0, bus.tx_data}, {24'd0, exp_b});
            end
        end
        if (!bus.tx_ready) pulsed_in_period = 1'b0;
        prev_valid = bus.tx_valid;
        prev_ready = bus.tx_ready;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic write_byte(input logic [7:0] d, input bit accept);
        bus.wr_en   = 1'b1;
        bus.wr_data = d;
        if (accept) exp_q.push_back(d);
        tick();
        bus.wr_en = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || !bus.tx_ready) && n < 1000) begin
            tick();
            n++;
        end
        check({name, "_drain_timeout"}, (n >= 1000) ? 32'd1 : 32'd0, 32'd0);
        tick();
        tick();
        check({name, "_busy"}, {31'd0, bus.busy}, 32'd0);
        check({name, "_level"}, {27'd0, bus.level}, 32'd0);
        check({name, "_empty"}, {31'd0, bus.empty}, 32'd1);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int p0;
        int n;
        bit got;
        hold_ready  = 1'b0;
        rst         = 1'b1;
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        bus.ovf_clr = 1'b0;
        tick(); tick(); tick();
        rst = 1'b0;

        // reset state
        check("rst_level", {27'd0, bus.level}, 32'd0);
        check("rst_empty", {31'd0, bus.empty}, 32'd1);
        check("rst_full", {31'd0, bus.full}, 32'd0);
        check("rst_overflow", {31'd0, bus.overflow}, 32'd0);
        check("rst_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
        check("rst_tx_data", {24'd0, bus.tx_data}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);

        // 1: single byte latency
        write_byte(8'h41, 1'b1);
        check("t1_level_after_write", {27'd0, bus.level}, 32'd1);
        check("t1_valid_early", {31'd0, bus.tx_valid}, 32'd0);
        tick();
        check("t1_valid", {31'd0, bus.tx_valid}, 32'd1);
        check("t1_data", {24'd0, bus.tx_data}, 32'h41);
        check("t1_level_after_pop", {27'd0, bus.level}, 32'd0);
        tick();
        check("t1_valid_one_cycle", {31'd0, bus.tx_valid}, 32'd0);
        wait_drain("t1");

        // 2: burst of 16 with ready held low
        hold_ready = 1'b1;
        tick(); tick();
        for (int i = 0; i < 16; i++) write_byte(8'(i), 1'b1);
        check("t2_full", {31'd0, bus.full}, 32'd1);
        check("t2_level", {27'd0, bus.level}, 32'd16);
        check("t2_empty", {31'd0, bus.empty}, 32'd0);
        p0 = pulse_cnt;
        hold_ready = 1'b0;
        wait_drain("t2");
        check("t2_pulses", pulse_cnt - p0, 32'd16);

        // 3: overflow, set-wins, clear
        hold_ready = 1'b1;
        tick(); tick();
        for (int i = 0; i < 16; i++) write_byte(8'h30 + 8'(i), 1'b1);
        check("t3_ovf_before", {31'd0, bus.overflow}, 32'd0);
        write_byte(8'hEE, 1'b0);
        check("t3_overflow", {31'd0, bus.overflow}, 32'd1);
        check("t3_level", {27'd0, bus.level}, 32'd16);
        bus.ovf_clr = 1'b1;
        write_byte(8'hEF, 1'b0);
        bus.ovf_clr = 1'b0;
        check("t3_set_wins", {31'd0, bus.overflow}, 32'd1);
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        check("t3_ovf_clr", {31'd0, bus.overflow}, 32'd0);
        p0 = pulse_cnt;
        hold_ready = 1'b0;
        wait_drain("t3");
        check("t3_pulses", pulse_cnt - p0, 32'd16);

        // 4: concurrent push+pop at level 5, then 40 bytes through with wrap
        hold_ready = 1'b1;
        tick(); tick();
        for (int i = 0; i < 5; i++) write_byte(8'h80 + 8'(i), 1'b1);
        check("t4_level5", {27'd0, bus.level}, 32'd5);
        p0 = pulse_cnt;
        hold_ready = 1'b0;
        tick();
        write_byte(8'h85, 1'b1);
        check("t4_pushpop_valid", {31'd0, bus.tx_valid}, 32'd1);
        check("t4_pushpop_level", {27'd0, bus.level}, 32'd5);
        for (int i = 1; i < 40; i++) begin
            n = 0;
            while (bus.full && n < 200) begin
                tick();
                n++;
            end
            check("t4_full_wait_timeout", (n >= 200) ? 32'd1 : 32'd0, 32'd0);
            write_byte(8'h85 + 8'(i), 1'b1);
        end
        wait_drain("t4");
        check("t4_pulses", pulse_cnt - p0, 32'd45);

        // 5: ready held low suppresses issue
        hold_ready = 1'b1;
        tick(); tick();
        for (int i = 0; i < 3; i++) write_byte(8'hC0 + 8'(i), 1'b1);
        p0 = pulse_cnt;
        repeat (20) tick();
        check("t5_no_pulse_held", pulse_cnt - p0, 32'd0);
        check("t5_level", {27'd0, bus.level}, 32'd3);
        hold_ready = 1'b0;
        wait_drain("t5");
        check("t5_pulses", pulse_cnt - p0, 32'd3);

        // 6: reset while in WAIT with 4 bytes queued
        hold_ready = 1'b1;
        tick(); tick();
        for (int i = 0; i < 5; i++) write_byte(8'hD0 + 8'(i), 1'b1);
        hold_ready = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (bus.tx_valid) begin
                got = 1'b1;
                break;
            end
        end
        check("t6_first_pulse_seen", {31'd0, got}, 32'd1);
        tick();
        check("t6_level_before_rst", {27'd0, bus.level}, 32'd4);
        rst = 1'b1;
        exp_q.delete();
        tick();
        rst = 1'b0;
        check("t6_level", {27'd0, bus.level}, 32'd0);
        check("t6_empty", {31'd0, bus.empty}, 32'd1);
        check("t6_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
        check("t6_overflow", {31'd0, bus.overflow}, 32'd0);
        p0 = pulse_cnt;
        repeat (30) tick();
        check("t6_no_pulse_after_rst", pulse_cnt - p0, 32'd0);
        write_byte(8'h5A, 1'b1);
        wait_drain("t6");
        check("t6_pulses_after_write", pulse_cnt - p0, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
